// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked frame, ACK.
// Define PS2_TX_RETRY_EN to retry a failed transfer once before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] wd_q, wd_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          doe_q, doe_d;
    logic          fail;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic fall;

`ifdef PS2_TX_RETRY_EN
    logic retry_q, retry_d;
`endif

    assign fall = clk_prev & ~clk_sync;

    // Synchronizers idle high so reset never fabricates a falling edge
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            wd_q      <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            doe_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            wd_q      <= wd_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            par_q     <= par_d;
            doe_q     <= doe_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        inh_cnt_d   = inh_cnt_q;
        wd_d        = wd_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        par_d       = par_q;
        doe_d       = doe_q;
        fail        = 1'b0;
        tx_ready    = 1'b0;
        busy        = 1'b1;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) begin
                    data_d    = tx_data;
                    par_d     = ~^tx_data;
                    inh_cnt_d = IW'(INHIBIT_CYCLES - 1);
                    state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt_q == '0) begin
                    // Start bit goes low while the clock is still held
                    ps2_data_oe = 1'b1;
                    doe_d       = 1'b1;
                    shift_d     = {par_q, data_q};
                    bit_cnt_d   = '0;
                    wd_d        = '0;
                    state_d     = SEND;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            SEND: begin
                ps2_data_oe = doe_q;
                wd_d        = wd_q + 1'b1;
                if (fall) begin
                    wd_d      = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        doe_d   = 1'b0;
                        state_d = ACK;
                    end else begin
                        doe_d   = ~shift_q[0];
                        shift_d = {1'b0, shift_q[8:1]};
                    end
                end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            ACK: begin
                wd_d = wd_q + 1'b1;
                if (fall) begin
                    wd_d = '0;
                    if (data_sync) fail = 1'b1;
                    else state_d = WAIT_IDLE;
                end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                wd_d = wd_q + 1'b1;
                if (clk_sync && data_sync) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    wd_d = '0;
                end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            doe_d       = 1'b0;
            tx_err      = 1'b1;
            state_d     = IDLE;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                tx_err    = 1'b0;
                retry_d   = 1'b1;
                inh_cnt_d = IW'(INHIBIT_CYCLES - 1);
                state_d   = INHIBIT;
            end
`endif
        end

        // A transfer cut short by reset reports nothing
        if (rst) begin
            tx_done = 1'b0;
            tx_err  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 device model.
// Frames and results are predicted from the byte and compared by separate monitors.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TO   = 5000;
    localparam int HALF = 20;

    logic       clk_100mhz = 1'b0;
    logic       rst        = 1'b1;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_valid   = 1'b0;
    logic       dev_clk    = 1'b1;
    logic       dev_data   = 1'b1;
    logic       tx_ready, ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk_100mhz = ~clk_100mhz;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    int         checks = 0;
    int         errors = 0;
    int         exp_res[$];
    logic [10:0] exp_frame[$];
    logic       done_prev = 1'b0;
    int         mon_e;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Line-level frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 8'd1) != 8'd0;
            if (f[i+1]) ones++;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Result monitor: 1 = tx_done, 2 = tx_err
    always @(negedge clk_100mhz) begin
        if (tx_done && tx_err) chk("done_err_overlap", 1, 0);
        if (tx_done || tx_err) begin
            if (exp_res.size() == 0) begin
                chk("unexpected_pulse", tx_done ? 1 : 2, 0);
            end else begin
                mon_e = exp_res.pop_front();
                chk("result", tx_done ? 1 : 2, mon_e);
            end
        end
        if (done_prev) chk("ready_after_done", int'(tx_ready), 1);
        done_prev <= tx_done;
    end

    task automatic issue(input logic [7:0] b, input bit hold);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 1000) begin
            @(negedge clk_100mhz);
            n++;
        end
        if (!tx_ready) chk("accept_timeout", 0, 1);
        @(negedge clk_100mhz);
        chk("busy_after_accept", int'(busy), 1);
        if (hold) tx_data = 8'h55;
        else tx_valid = 1'b0;
    endtask

    // mode 0: full frame with given ACK level; 1: never clock; 2: stop after 4 edges
    task automatic device(input int mode, input bit ack_bit);
        int n;
        int inh;
        logic [10:0] got;
        logic [10:0] exp;
        n = 0;
        got = '0;
        while (!ps2_clk_oe && n < 20000) begin
            @(negedge clk_100mhz);
            n++;
        end
        if (!ps2_clk_oe) begin
            chk("inhibit_missing", 0, 1);
            return;
        end
        inh = 0;
        while (ps2_clk_oe && inh < 20000) begin
            @(negedge clk_100mhz);
            inh++;
        end
        chk("inhibit_len", inh, INH);
        got[0] = ps2_data_in;
        chk("start_bit", int'(ps2_data_in), 0);
        if (mode == 1) begin
            n = 0;
            while (!tx_err && !ps2_clk_oe && n < 6000) begin
                @(negedge clk_100mhz);
                n++;
            end
            chk("timeout_window", int'(n >= TO - 2 && n <= TO + 1), 1);
            if (tx_err) chk("timeout_release", int'({ps2_clk_oe, ps2_data_oe}), 0);
            return;
        end
        repeat (5) @(negedge clk_100mhz);
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk_100mhz);
            got[k] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk_100mhz);
            if (mode == 2 && k == 4) return;
        end
        if (exp_frame.size() == 0) begin
            chk("frame_unexpected", int'(got), 0);
        end else begin
            exp = exp_frame.pop_front();
            chk("frame", int'(got), int'(exp));
        end
        dev_data = ack_bit;
        repeat (3) @(negedge clk_100mhz);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk_100mhz);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        dev_data = 1'b1;
        n = 0;
        while (busy && !ps2_clk_oe && n < 200) begin
            @(negedge clk_100mhz);
            n++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "bench hung");
    end

    initial begin
        int quiet;
        logic [7:0] rb;
        rst = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        chk("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk("rst_data_oe", int'(ps2_data_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(tx_done), 0);
        chk("rst_err", int'(tx_err), 0);
        rst = 1'b0;
        @(negedge clk_100mhz);
        chk("rst_ready", int'(tx_ready), 1);

        exp_frame.push_back(frame_of(8'hED));
        exp_res.push_back(1);
        issue(8'hED, 1'b0);
        device(0, 1'b0);
        repeat (10) @(negedge clk_100mhz);

        exp_frame.push_back(frame_of(8'hFF));
        exp_res.push_back(1);
        issue(8'hFF, 1'b0);
        device(0, 1'b0);
        repeat (10) @(negedge clk_100mhz);

        exp_frame.push_back(frame_of(8'hA5));
`ifdef PS2_TX_RETRY_EN
        exp_frame.push_back(frame_of(8'hA5));
        exp_res.push_back(1);
        issue(8'hA5, 1'b0);
        device(0, 1'b1);
        device(0, 1'b0);
`else
        exp_res.push_back(2);
        issue(8'hA5, 1'b0);
        device(0, 1'b1);
`endif
        repeat (10) @(negedge clk_100mhz);

        exp_res.push_back(2);
        issue(8'h3C, 1'b0);
        device(1, 1'b0);
`ifdef PS2_TX_RETRY_EN
        device(1, 1'b0);
`endif
        repeat (10) @(negedge clk_100mhz);

        issue(8'h00, 1'b0);
        device(2, 1'b0);
        chk("abort_data_driven", int'(ps2_data_oe), 1);
        rst = 1'b1;
        @(negedge clk_100mhz);
        chk("abort_clk_oe", int'(ps2_clk_oe), 0);
        chk("abort_data_oe", int'(ps2_data_oe), 0);
        chk("abort_ready", int'(tx_ready), 1);
        chk("abort_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk_100mhz);

        exp_frame.push_back(frame_of(8'hF4));
        exp_res.push_back(1);
        issue(8'hF4, 1'b0);
        device(0, 1'b0);
        repeat (10) @(negedge clk_100mhz);

        exp_frame.push_back(frame_of(8'hED));
        exp_res.push_back(1);
        issue(8'hED, 1'b1);
        device(0, 1'b0);
        tx_valid = 1'b0;
        quiet = 0;
        repeat (300) begin
            @(negedge clk_100mhz);
            if (busy || ps2_clk_oe) quiet = 1;
        end
        chk("held_valid_not_queued", quiet, 0);

        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            exp_frame.push_back(frame_of(rb));
            exp_res.push_back(1);
            issue(rb, 1'b0);
            device(0, 1'b0);
            repeat (10) @(negedge clk_100mhz);
        end

        repeat (20) @(negedge clk_100mhz);
        chk("results_drained", exp_res.size(), 0);
        chk("frames_drained", exp_frame.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
